tile_order_sequencer: RTL and testbench

- Consumer side of the board-layout order vectors: captures one packed edge-tile order (24 entries) and one packed center-tile order (12 entries).
- Validates the captured orders, then serves tile indices one at a time to the game/display logic through request pulses.
- Sits between the order source and the board renderer / tile-reveal FSM.

---
 rtl/tile_order_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_tile_order_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_order_sequencer.sv
// Tile order sequencer: captures packed edge/center tile orders, validates them
// and then serves one tile index per request to the board renderer.
module tile_order_sequencer #(
    parameter int EDGE_N     = 24,
    parameter int CENTER_N   = 12,
    parameter int IDX_W      = 4,
    parameter int TILE_MAX   = 11,
    parameter int EDGE_REPS  = 2,
    parameter int CHECK_MULT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [EDGE_N*IDX_W-1:0]   edge_order_in,
    input  logic [CENTER_N*IDX_W-1:0] center_order_in,
    input  logic                      edge_req,
    input  logic                      center_req,
    output logic                      busy,
    output logic                      ready,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic                      edge_valid,
    output logic [IDX_W-1:0]          edge_idx,
    output logic [4:0]                edge_pos,
    output logic                      edge_wrap,
    output logic                      center_valid,
    output logic [IDX_W-1:0]          center_idx,
    output logic [3:0]                center_pos,
    output logic                      center_wrap
);

    localparam int SCAN_N = EDGE_N + CENTER_N;
    localparam int BINS   = TILE_MAX + 1;
    localparam int CNT_W  = $clog2(SCAN_N + 1);

    typedef enum logic [1:0] {IDLE, CHECK, READY, ERROR} state_t;

    state_t                    state, state_nxt;
    logic [EDGE_N*IDX_W-1:0]   edge_store;
    logic [CENTER_N*IDX_W-1:0] center_store;
    logic [CNT_W-1:0]          scan_cnt;
    logic [1:0]                hist [BINS];
    logic [1:0]                err_reg, err_nxt;
    logic [IDX_W-1:0]          scan_entry;
    logic                      scan_active, scan_is_edge, scan_range_err;
    logic                      mult_err, scan_done;
    logic [IDX_W-1:0]          edge_cur, center_cur;

    // Entry 0 sits in the most significant nibble of each packed vector.
    always_comb begin
        scan_entry   = '0;
        scan_is_edge = (scan_cnt < CNT_W'(EDGE_N));
        scan_active  = (state == CHECK) && (scan_cnt < CNT_W'(SCAN_N));
        if (scan_is_edge)
            scan_entry = edge_store[(EDGE_N-1-int'(scan_cnt))*IDX_W +: IDX_W];
        else if (scan_cnt < CNT_W'(SCAN_N))
            scan_entry = center_store[(SCAN_N-1-int'(scan_cnt))*IDX_W +: IDX_W];
    end

    assign scan_range_err = scan_active && (scan_entry > IDX_W'(TILE_MAX));
    assign edge_cur       = edge_store[(EDGE_N-1-int'(edge_pos))*IDX_W +: IDX_W];
    assign center_cur     = center_store[(CENTER_N-1-int'(center_pos))*IDX_W +: IDX_W];

    always_comb begin
        mult_err = 1'b0;
        for (int b = 0; b < BINS; b++)
            if (hist[b] != 2'(EDGE_REPS))
                mult_err = 1'b1;
    end

    // Without the multiplicity pass the decision is taken on the last scan edge.
    always_comb begin
        if (CHECK_MULT != 0)
            scan_done = (state == CHECK) && (scan_cnt == CNT_W'(SCAN_N));
        else
            scan_done = (state == CHECK) && (scan_cnt == CNT_W'(SCAN_N - 1));
        err_nxt = err_reg;
        if (scan_range_err)
            err_nxt[0] = 1'b1;
        if ((CHECK_MULT != 0) && scan_done && mult_err)
            err_nxt[1] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        ready        = 1'b0;
        error        = 1'b0;
        err_code     = '0;
        edge_valid   = 1'b0;
        center_valid = 1'b0;
        edge_idx     = '0;
        center_idx   = '0;
        case (state)
            IDLE: ;
            CHECK: begin
                busy = 1'b1;
                if (scan_done)
                    state_nxt = (err_nxt == 2'b00) ? READY : ERROR;
            end
            READY: begin
                ready        = 1'b1;
                edge_valid   = 1'b1;
                center_valid = 1'b1;
                edge_idx     = edge_cur;
                center_idx   = center_cur;
            end
            ERROR: begin
                error    = 1'b1;
                err_code = err_reg;
            end
            default: state_nxt = IDLE;
        endcase
        if (load)
            state_nxt = CHECK;
    end

    // Load wins over requests; requests only move pointers while serving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_store   <= '0;
            center_store <= '0;
            scan_cnt     <= '0;
            err_reg      <= '0;
            edge_pos     <= '0;
            center_pos   <= '0;
            edge_wrap    <= 1'b0;
            center_wrap  <= 1'b0;
            for (int b = 0; b < BINS; b++)
                hist[b] <= '0;
        end else if (load) begin
            edge_store   <= edge_order_in;
            center_store <= center_order_in;
            scan_cnt     <= '0;
            err_reg      <= '0;
            edge_pos     <= '0;
            center_pos   <= '0;
            edge_wrap    <= 1'b0;
            center_wrap  <= 1'b0;
            for (int b = 0; b < BINS; b++)
                hist[b] <= '0;
        end else begin
            edge_wrap   <= 1'b0;
            center_wrap <= 1'b0;
            if (state == CHECK) begin
                err_reg <= err_nxt;
                if (scan_cnt < CNT_W'(SCAN_N))
                    scan_cnt <= scan_cnt + CNT_W'(1);
                for (int b = 0; b < BINS; b++)
                    if (scan_active && scan_is_edge && (scan_entry == IDX_W'(b)) &&
                        (hist[b] != 2'd3))
                        hist[b] <= hist[b] + 2'd1;
            end
            if (state == READY) begin
                if (edge_req) begin
                    if (edge_pos == 5'(EDGE_N - 1)) begin
                        edge_pos  <= '0;
                        edge_wrap <= 1'b1;
                    end else begin
                        edge_pos <= edge_pos + 5'd1;
                    end
                end
                if (center_req) begin
                    if (center_pos == 4'(CENTER_N - 1)) begin
                        center_pos  <= '0;
                        center_wrap <= 1'b1;
                    end else begin
                        center_pos <= center_pos + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tile_order_sequencer.sv
// Scoreboard bench for tile_order_sequencer: a multiplicity-checking instance (a)
// and a range-only instance (b) share stimulus; expected indices are queued per request.
module tb_tile_order_sequencer;

    logic        clk = 1'b0;
    logic        rst, load, edge_req, center_req;
    logic [95:0] edge_order_in;
    logic [47:0] center_order_in;

    logic       busy_a, ready_a, error_a, edge_valid_a, edge_wrap_a, center_valid_a, center_wrap_a;
    logic [1:0] err_code_a;
    logic [3:0] edge_idx_a, center_idx_a, center_pos_a;
    logic [4:0] edge_pos_a;
    logic       busy_b, ready_b, error_b, edge_valid_b, edge_wrap_b, center_valid_b, center_wrap_b;
    logic [1:0] err_code_b;
    logic [3:0] edge_idx_b, center_idx_b, center_pos_b;
    logic [4:0] edge_pos_b;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_arr [24];
    int center_arr [12];
    int exp_edge_q [$];
    int exp_center_q [$];
    int model_epos, model_cpos, model_ready;

    always #5 clk = ~clk;

    tile_order_sequencer #(.CHECK_MULT(1)) dut_a (
        .clk(clk), .rst(rst), .load(load),
        .edge_order_in(edge_order_in), .center_order_in(center_order_in),
        .edge_req(edge_req), .center_req(center_req),
        .busy(busy_a), .ready(ready_a), .error(error_a), .err_code(err_code_a),
        .edge_valid(edge_valid_a), .edge_idx(edge_idx_a), .edge_pos(edge_pos_a),
        .edge_wrap(edge_wrap_a), .center_valid(center_valid_a), .center_idx(center_idx_a),
        .center_pos(center_pos_a), .center_wrap(center_wrap_a)
    );

    tile_order_sequencer #(.CHECK_MULT(0)) dut_b (
        .clk(clk), .rst(rst), .load(load),
        .edge_order_in(edge_order_in), .center_order_in(center_order_in),
        .edge_req(edge_req), .center_req(center_req),
        .busy(busy_b), .ready(ready_b), .error(error_b), .err_code(err_code_b),
        .edge_valid(edge_valid_b), .edge_idx(edge_idx_b), .edge_pos(edge_pos_b),
        .edge_wrap(edge_wrap_b), .center_valid(center_valid_b), .center_idx(center_idx_b),
        .center_pos(center_pos_b), .center_wrap(center_wrap_b)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Independent reference: count occurrences, flag range and multiplicity faults.
    function automatic int model_err(input int mult);
        int cnt [12];
        int code;
        code = 0;
        foreach (cnt[b]) cnt[b] = 0;
        foreach (edge_arr[i]) begin
            if (edge_arr[i] > 11) code = code | 1;
            else cnt[edge_arr[i]]++;
        end
        foreach (center_arr[i])
            if (center_arr[i] > 11) code = code | 1;
        if (mult != 0)
            foreach (cnt[b])
                if (cnt[b] != 2) code = code | 2;
        return code;
    endfunction

    task automatic check_idle(input string tag);
        checkOutput({tag, "_busy"}, int'(busy_a), 0);
        checkOutput({tag, "_ready"}, int'(ready_a), 0);
        checkOutput({tag, "_error"}, int'(error_a), 0);
        checkOutput({tag, "_err_code"}, int'(err_code_a), 0);
        checkOutput({tag, "_edge_valid"}, int'(edge_valid_a), 0);
        checkOutput({tag, "_center_valid"}, int'(center_valid_a), 0);
        checkOutput({tag, "_edge_pos"}, int'(edge_pos_a), 0);
        checkOutput({tag, "_center_pos"}, int'(center_pos_a), 0);
        checkOutput({tag, "_edge_idx"}, int'(edge_idx_a), 0);
        checkOutput({tag, "_edge_wrap"}, int'(edge_wrap_a), 0);
    endtask

    task automatic applyStimulus(input string tag, input logic with_req);
        int busy_cnt_a, busy_cnt_b, code_a, code_b;
        for (int i = 0; i < 24; i++) edge_order_in[(23-i)*4 +: 4] = 4'(edge_arr[i]);
        for (int i = 0; i < 12; i++) center_order_in[(11-i)*4 +: 4] = 4'(center_arr[i]);
        code_a = model_err(1);
        code_b = model_err(0);
        load = 1'b1;
        edge_req = with_req;
        @(posedge clk); #1;
        load = 1'b0;
        edge_req = 1'b0;
        if (with_req) begin
            checkOutput({tag, "_load_edge_pos"}, int'(edge_pos_a), 0);
            checkOutput({tag, "_load_wrap"}, int'(edge_wrap_a), 0);
            checkOutput({tag, "_load_busy"}, int'(busy_a), 1);
        end
        busy_cnt_a = 0;
        busy_cnt_b = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (!busy_a && !busy_b) break;
            busy_cnt_a += int'(busy_a);
            busy_cnt_b += int'(busy_b);
            @(posedge clk); #1;
        end
        checkOutput({tag, "_busy_cycles_a"}, busy_cnt_a, 37);
        checkOutput({tag, "_busy_cycles_b"}, busy_cnt_b, 36);
        checkOutput({tag, "_ready_a"}, int'(ready_a), int'(code_a == 0));
        checkOutput({tag, "_error_a"}, int'(error_a), int'(code_a != 0));
        checkOutput({tag, "_err_code_a"}, int'(err_code_a), code_a);
        checkOutput({tag, "_ready_b"}, int'(ready_b), int'(code_b == 0));
        checkOutput({tag, "_err_code_b"}, int'(err_code_b), code_b);
        if (code_a == 0) begin
            checkOutput({tag, "_edge_idx0"}, int'(edge_idx_a), edge_arr[0]);
            checkOutput({tag, "_center_idx0"}, int'(center_idx_a), center_arr[0]);
            checkOutput({tag, "_edge_pos0"}, int'(edge_pos_a), 0);
        end else begin
            checkOutput({tag, "_edge_valid_err"}, int'(edge_valid_a), 0);
        end
        model_ready = int'(code_a == 0);
        model_epos  = 0;
        model_cpos  = 0;
        exp_edge_q.delete();
        exp_center_q.delete();
    endtask

    // Single-cycle pulses with an idle cycle between them to see the wrap pulse drop.
    task automatic pulse_edge_req(input string tag, input int n);
        int wrap_exp;
        for (int i = 0; i < n; i++) begin
            edge_req = 1'b1;
            wrap_exp = 0;
            if (model_ready != 0) begin
                model_epos = (model_epos + 1) % 24;
                wrap_exp   = int'(model_epos == 0);
                exp_edge_q.push_back(edge_arr[model_epos]);
            end
            @(posedge clk); #1;
            edge_req = 1'b0;
            if (model_ready != 0)
                checkOutput({tag, "_edge_idx"}, int'(edge_idx_a), exp_edge_q.pop_front());
            checkOutput({tag, "_edge_pos"}, int'(edge_pos_a), model_epos);
            checkOutput({tag, "_edge_wrap"}, int'(edge_wrap_a), wrap_exp);
            @(posedge clk); #1;
            checkOutput({tag, "_edge_wrap_drop"}, int'(edge_wrap_a), 0);
        end
    endtask

    // Held request: one advance per cycle while high.
    task automatic hold_center_req(input string tag, input int n);
        int wrap_exp;
        center_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            wrap_exp = 0;
            if (model_ready != 0) begin
                model_cpos = (model_cpos + 1) % 12;
                wrap_exp   = int'(model_cpos == 0);
                exp_center_q.push_back(center_arr[model_cpos]);
            end
            @(posedge clk); #1;
            if (i == n - 1) center_req = 1'b0;
            if (model_ready != 0)
                checkOutput({tag, "_center_idx"}, int'(center_idx_a), exp_center_q.pop_front());
            checkOutput({tag, "_center_pos"}, int'(center_pos_a), model_cpos);
            checkOutput({tag, "_center_wrap"}, int'(center_wrap_a), wrap_exp);
        end
        @(posedge clk); #1;
        checkOutput({tag, "_center_wrap_drop"}, int'(center_wrap_a), 0);
    endtask

    task automatic set_legal();
        edge_arr   = '{10, 1, 4, 3, 0, 2, 5, 6, 7, 8, 9, 11,
                       11, 9, 8, 7, 6, 5, 2, 0, 3, 4, 1, 10};
        center_arr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    endtask

    task automatic set_twice_ramp();
        for (int i = 0; i < 24; i++) edge_arr[i] = i % 12;
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        edge_req = 1'b0;
        center_req = 1'b0;
        edge_order_in = '0;
        center_order_in = '0;
        #12;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        set_legal();
        applyStimulus("legal", 1'b0);
        pulse_edge_req("walk", 24);
        hold_center_req("cwalk", 12);
        edge_req = 1'b1;
        center_req = 1'b1;
        @(posedge clk); #1;
        edge_req = 1'b0;
        center_req = 1'b0;
        checkOutput("dual_edge_pos", int'(edge_pos_a), 1);
        checkOutput("dual_center_pos", int'(center_pos_a), 1);

        set_twice_ramp();
        foreach (center_arr[i]) center_arr[i] = 0;
        applyStimulus("zeros", 1'b0);
        hold_center_req("zwalk", 12);

        set_twice_ramp();
        edge_arr[5] = 15;
        applyStimulus("range", 1'b0);
        pulse_edge_req("err_req", 2);
        checkOutput("err_edge_valid", int'(edge_valid_a), 0);

        set_twice_ramp();
        edge_arr[19] = 8;
        center_arr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
        applyStimulus("mult", 1'b0);

        set_legal();
        for (int i = 0; i < 24; i++) edge_order_in[(23-i)*4 +: 4] = 4'(edge_arr[i]);
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (19) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_idle("midscan_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_busy", int'(busy_a), 0);

        applyStimulus("legal2", 1'b0);
        pulse_edge_req("to23", 23);
        applyStimulus("reload", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
